// File: rtl/vga_palette_arbiter.sv
// Palette RAM arbiter: display scan-out reads own the single RAM port; host writes
// are queued in a small FIFO and drained on free cycles, optionally only in vblank.
module vga_palette_arbiter #(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic [DATA_W-1:0] o_disp_data,
   output logic              o_disp_valid,
   input  logic              i_host_wr_valid,
   output logic              o_host_wr_ready,
   input  logic [ADDR_W-1:0] i_host_wr_addr,
   input  logic [DATA_W-1:0] i_host_wr_data,
   input  logic              i_lock_en,
   input  logic              i_vblank,
   output logic              o_mem_en_c,
   output logic              o_mem_we_c,
   output logic [ADDR_W-1:0] o_mem_addr_c,
   output logic [DATA_W-1:0] o_mem_wdata_c,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [LVL_W-1:0]  o_fifo_level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   wr_entry_t         r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_ready;
   logic              r_rd_pend;
   logic              r_disp_valid;
   logic [DATA_W-1:0] r_disp_data;

   wr_entry_t         w_head;
   logic              w_empty;
   logic              w_drain_ok;
   logic              w_push;
   logic              w_pop;
   logic [LVL_W-1:0]  w_level_nxt;

   assign w_head = r_fifo[r_rptr];

   // Per-cycle grant: display read first, then a FIFO drain if the lock allows it.
   always_comb begin
      w_empty       = (r_level == '0);
      w_drain_ok    = !i_lock_en || i_vblank;
      w_pop         = !rst && !i_disp_req && !w_empty && w_drain_ok;
      w_push        = !rst && i_host_wr_valid && r_ready;
      o_mem_en_c    = (!rst && i_disp_req) || w_pop;
      o_mem_we_c    = w_pop;
      o_mem_addr_c  = i_disp_req ? i_disp_addr : w_head.addr;
      o_mem_wdata_c = w_head.data;
      w_level_nxt   = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
   end

   // Ready is registered from the next level, so a pop never bypasses a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_level      <= '0;
         r_ready      <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_data  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_level      <= w_level_nxt;
         r_ready      <= (w_level_nxt < LVL_W'(FIFO_DEPTH));
         r_rd_pend    <= i_disp_req;
         r_disp_valid <= r_rd_pend;
         if (r_rd_pend) r_disp_data <= i_mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= wr_entry_t'{addr: i_host_wr_addr, data: i_host_wr_data};
   end

   assign o_disp_data     = r_disp_data;
   assign o_disp_valid    = r_disp_valid;
   assign o_host_wr_ready = r_ready;
   assign o_fifo_level    = r_level;

endmodule
